// File: rtl/usb2_tx_serializer.sv
// usb2_tx_serializer: byte-wide UTMI-style transmit path to an NRZI line.
// Sends SYNC, LSB-first data with bit stuffing, then EOP. One line bit every
// OVERSAMPLE clocks.
// Optional build macro: USB2_TX_HS_EOP_EN selects a high-speed style EOP
// (0xFE through NRZI with stuffing suppressed). Otherwise a full-speed
// SE0,SE0,J EOP is sent.
module usb2_tx_serializer #(
  parameter int OVERSAMPLE = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_dp,
  output logic       tx_dm,
  output logic       tx_oe,
  output logic       tx_active
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

`ifdef USB2_TX_HS_EOP_EN
  localparam logic [7:0] HS_EOP_BYTE = 8'hFE;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_EOP  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;   // bits emitted in current SYNC/byte/EOP
  logic [2:0]    ones_reg, ones_next;         // consecutive data ones on the line
  logic [7:0]    shift_reg, shift_next;
  logic          level_reg, level_next;       // NRZI level, 1 = J
  logic          dp_reg, dp_next;
  logic          dm_reg, dm_next;
  logic          oe_reg, oe_next;
  logic          active_reg, active_next;

  logic          tick;
  logic          do_emit;
  logic          emit_bit;
  logic          enter_eop;
  logic [3:0]    eop_idx;

  assign tick      = (tick_cnt_reg == TW'(OVERSAMPLE - 1));
  assign tx_dp     = dp_reg;
  assign tx_dm     = dm_reg;
  assign tx_oe     = oe_reg;
  assign tx_active = active_reg;

  // State and line registers; reset parks the line at J with the driver off.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      ones_reg     <= '0;
      shift_reg    <= '0;
      level_reg    <= 1'b1;
      dp_reg       <= 1'b1;
      dm_reg       <= 1'b0;
      oe_reg       <= 1'b0;
      active_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      ones_reg     <= ones_next;
      shift_reg    <= shift_next;
      level_reg    <= level_next;
      dp_reg       <= dp_next;
      dm_reg       <= dm_next;
      oe_reg       <= oe_next;
      active_reg   <= active_next;
    end
  end

  // Next-state, line symbol and handshake; everything except the tick
  // counter moves only on bit-tick cycles.
  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick ? '0 : TW'(tick_cnt_reg + 1'b1);
    bit_cnt_next  = bit_cnt_reg;
    ones_next     = ones_reg;
    shift_next    = shift_reg;
    level_next    = level_reg;
    dp_next       = dp_reg;
    dm_next       = dm_reg;
    oe_next       = oe_reg;
    tx_ready      = 1'b0;
    do_emit       = 1'b0;
    emit_bit      = 1'b0;
    enter_eop     = 1'b0;
    eop_idx       = bit_cnt_reg;

    if (tick) begin
      case (state_reg)
        ST_IDLE: begin
          level_next = 1'b1;
          dp_next    = 1'b1;
          dm_next    = 1'b0;
          oe_next    = 1'b0;
          if (tx_valid) begin
            // SYNC bit 0 goes out on this same tick
            state_next   = ST_SYNC;
            do_emit      = 1'b1;
            emit_bit     = 1'b0;
            bit_cnt_next = 4'd1;
            ones_next    = '0;
            oe_next      = 1'b1;
          end
        end
        ST_SYNC: begin
          do_emit      = 1'b1;
          emit_bit     = (bit_cnt_reg == 4'd7);
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd7) begin
            // park at a byte boundary; the trailing SYNC 1 counts toward stuffing
            state_next = ST_DATA;
            ones_next  = 3'd1;
          end
        end
        ST_DATA: begin
          if (ones_reg == 3'd6) begin
            // stuffed 0; shift register and bit count hold
            do_emit   = 1'b1;
            emit_bit  = 1'b0;
            ones_next = '0;
          end else if (bit_cnt_reg == 4'd8) begin
            if (tx_valid) begin
              tx_ready     = 1'b1;
              do_emit      = 1'b1;
              emit_bit     = tx_data[0];
              shift_next   = {1'b0, tx_data[7:1]};
              bit_cnt_next = 4'd1;
              ones_next    = tx_data[0] ? 3'(ones_reg + 3'd1) : 3'd0;
            end else begin
              enter_eop = 1'b1;
            end
          end else begin
            do_emit      = 1'b1;
            emit_bit     = shift_reg[0];
            shift_next   = {1'b0, shift_reg[7:1]};
            bit_cnt_next = bit_cnt_reg + 4'd1;
            ones_next    = shift_reg[0] ? 3'(ones_reg + 3'd1) : 3'd0;
          end
        end
        default: ;
      endcase

      // EOP sequencing, shared by the entry tick and the EOP state itself
      if (enter_eop || (state_reg == ST_EOP)) begin
        eop_idx      = enter_eop ? 4'd0 : bit_cnt_reg;
        state_next   = ST_EOP;
        bit_cnt_next = eop_idx + 4'd1;
        ones_next    = '0;
        oe_next      = 1'b1;
`ifdef USB2_TX_HS_EOP_EN
        if (eop_idx < 4'd8) begin
          do_emit  = 1'b1;
          emit_bit = HS_EOP_BYTE[eop_idx[2:0]];
        end else begin
          state_next   = ST_IDLE;
          bit_cnt_next = '0;
          level_next   = 1'b1;
          dp_next      = 1'b1;
          dm_next      = 1'b0;
          oe_next      = 1'b0;
        end
`else
        if (eop_idx < 4'd2) begin
          dp_next = 1'b0;
          dm_next = 1'b0;
        end else if (eop_idx == 4'd2) begin
          level_next = 1'b1;
          dp_next    = 1'b1;
          dm_next    = 1'b0;
        end else begin
          state_next   = ST_IDLE;
          bit_cnt_next = '0;
          level_next   = 1'b1;
          dp_next      = 1'b1;
          dm_next      = 1'b0;
          oe_next      = 1'b0;
        end
`endif
      end

      // NRZI: a 0 toggles the level, a 1 holds it
      if (do_emit) begin
        level_next = emit_bit ? level_reg : ~level_reg;
        dp_next    = level_next;
        dm_next    = ~level_next;
      end
    end

    active_next = (state_next != ST_IDLE);
  end

endmodule

// File: tb/tb_usb2_tx_serializer.sv
// tb_usb2_tx_serializer: directed stimulus with a symbol scoreboard. Each
// packet pushes its expected line symbols (SYNC, stuffed NRZI data, EOP)
// and tx_ready flags; one symbol is popped and compared per bit tick.
module tb_usb2_tx_serializer;

  localparam int OS = 5;
`ifdef USB2_TX_HS_EOP_EN
  localparam int EOP_BITS = 8;
`else
  localparam int EOP_BITS = 3;
`endif

  logic       clock;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_dp;
  logic       tx_dm;
  logic       tx_oe;
  logic       tx_active;

  usb2_tx_serializer #(.OVERSAMPLE(OS)) dut (
    .clock     (clock),
    .reset     (reset),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_dp     (tx_dp),
    .tx_dm     (tx_dm),
    .tx_oe     (tx_oe),
    .tx_active (tx_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // sym = {active, oe, dp, dm}
  typedef struct packed {
    logic       rdy;
    logic       last;
    logic [3:0] sym;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] drv_q[$];
  int         rdy_ticks[$];
  int         pass_cnt = 0;
  int         fail_cnt = 0;
  int         total_cnt = 0;
  int         phase = 0;
  int         tick_no = 0;
  int         oe_cnt = 0;
  int         ready_cnt = 0;
  logic       pkt_active = 1'b0;
  logic       started = 1'b0;
  logic       m_level;
  int         m_ones;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock; phase mirrors the DUT tick counter (reset forces it to 0)
  task automatic step();
    @(posedge clock);
    #1;
    if (reset) phase = 0;
    else phase = (phase + 1) % OS;
  endtask

  task automatic push_sym(input logic rdy, input logic last, input logic [3:0] s);
    exp_t e;
    e.rdy  = rdy;
    e.last = last;
    e.sym  = s;
    exp_q.push_back(e);
  endtask

  task automatic push_nrzi(input logic rdy, input logic b);
    if (!b) m_level = ~m_level;
    push_sym(rdy, 1'b0, {2'b11, m_level, ~m_level});
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_sym(1'b0, 1'b0, 4'b0010);
  endtask

  // expected symbols for the bytes currently in drv_q
  task automatic push_packet();
    logic [7:0] cur;
    logic [7:0] eop;
    logic       b;
    m_level = 1'b1;
    m_ones  = 0;
    for (int i = 0; i < 8; i++) begin
      b = (i == 7);
      push_nrzi(1'b0, b);
      m_ones = b ? m_ones + 1 : 0;
    end
    foreach (drv_q[j]) begin
      cur = drv_q[j];
      for (int k = 0; k < 8; k++) begin
        b = cur[k];
        push_nrzi(k == 0, b);
        m_ones = b ? m_ones + 1 : 0;
        if (m_ones == 6) begin
          push_nrzi(1'b0, 1'b0);
          m_ones = 0;
        end
      end
    end
`ifdef USB2_TX_HS_EOP_EN
    eop = 8'hFE;
    for (int k = 0; k < 8; k++) push_nrzi(1'b0, eop[k]);
`else
    eop = 8'h00;
    push_sym(1'b0, eop[0], 4'b1100);
    push_sym(1'b0, 1'b0, 4'b1100);
    push_sym(1'b0, 1'b0, 4'b1110);
`endif
    push_sym(1'b0, 1'b1, 4'b0010);
    pkt_active = 1'b1;
    started    = 1'b0;
    oe_cnt     = 0;
    ready_cnt  = 0;
    rdy_ticks.delete();
  endtask

  // pop and compare up to n symbols (all of them when n < 0)
  task automatic run_bits(input int n);
    exp_t e;
    logic rdy;
    int   done = 0;
    while (exp_q.size() > 0 && (n < 0 || done < n)) begin
      e = exp_q.pop_front();
      tx_valid = pkt_active && (!started || drv_q.size() != 0);
      tx_data  = (drv_q.size() != 0) ? drv_q[0] : 8'h00;
      while (phase != OS - 1) begin
        check("ready_off_tick", 32'(tx_ready), 32'(0));
        step();
      end
      rdy = tx_ready;
      check("ready", 32'(rdy), 32'(e.rdy));
      if (rdy) begin
        ready_cnt++;
        rdy_ticks.push_back(tick_no);
        if (drv_q.size() != 0) drv_q.delete(0);
      end
      step();
      check("line", 32'({tx_active, tx_oe, tx_dp, tx_dm}), 32'(e.sym));
      if (tx_oe) oe_cnt++;
      tick_no++;
      started = 1'b1;
      if (e.last) pkt_active = 1'b0;
      done++;
    end
    tx_valid = pkt_active && (!started || drv_q.size() != 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dp"}, 32'(tx_dp), 32'(1));
    check({tag, "_dm"}, 32'(tx_dm), 32'(0));
    check({tag, "_oe"}, 32'(tx_oe), 32'(0));
    check({tag, "_active"}, 32'(tx_active), 32'(0));
    check({tag, "_ready"}, 32'(tx_ready), 32'(0));
  endtask

  initial begin
    int d;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    for (int i = 0; i < 3; i++) step();
    check_reset_state("reset");
    reset = 1'b0;

    // idle line stays J with tx_valid low
    push_idle(3);
    run_bits(-1);
    $display("idle: 3 bits J");

    // single 0x00: 19 bit times of oe (full-speed EOP), one ready
    drv_q = '{8'h00};
    push_packet();
    run_bits(-1);
    check("oe_bits_00", 32'(oe_cnt), 32'(16 + EOP_BITS));
    check("ready_pulses_00", 32'(ready_cnt), 32'(1));
    $display("packet 00: oe_bits=%0d ready=%0d", oe_cnt, ready_cnt);

    // single 0xFF: one stuffed bit -> 9 data-phase bit times
    drv_q = '{8'hFF};
    push_packet();
    run_bits(-1);
    check("oe_bits_ff", 32'(oe_cnt), 32'(8 + 9 + EOP_BITS));
    check("ready_pulses_ff", 32'(ready_cnt), 32'(1));
    $display("packet ff: oe_bits=%0d ready=%0d", oe_cnt, ready_cnt);

    // 0x3F then 0x01, started back-to-back on the first IDLE tick
    drv_q = '{8'h3F, 8'h01};
    push_packet();
    run_bits(-1);
    check("ready_pulses_3f01", 32'(ready_cnt), 32'(2));
    d = (rdy_ticks.size() >= 2) ? rdy_ticks[1] - rdy_ticks[0] : -1;
    check("ready_spacing_3f01", 32'(d), 32'(9));
    $display("packet 3f 01: ready=%0d spacing=%0d", ready_cnt, d);

    // tx_valid drops during SYNC: EOP right after SYNC, no ready
    drv_q = {};
    push_packet();
    run_bits(-1);
    check("ready_pulses_empty", 32'(ready_cnt), 32'(0));
    check("oe_bits_empty", 32'(oe_cnt), 32'(8 + EOP_BITS));
    $display("packet empty: oe_bits=%0d ready=%0d", oe_cnt, ready_cnt);

    // reset in the middle of DATA: reset values next cycle, no EOP after
    drv_q = '{8'h55, 8'hAA};
    push_packet();
    run_bits(12);
    step();
    step();
    reset = 1'b1;
    step();
    check_reset_state("mid_reset");
    step();
    step();
    reset      = 1'b0;
    tx_valid   = 1'b0;
    pkt_active = 1'b0;
    exp_q.delete();
    drv_q.delete();
    push_idle(4);
    run_bits(-1);
    $display("mid-data reset: line back to J, no SE0");

    // recovery: ones runs crossing byte boundaries
    drv_q = '{8'hA5, 8'hFF, 8'hFF};
    push_packet();
    run_bits(-1);
    check("ready_pulses_a5ffff", 32'(ready_cnt), 32'(3));
    $display("packet a5 ff ff: oe_bits=%0d ready=%0d", oe_cnt, ready_cnt);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
